// File: rtl/text_console.sv
`default_nettype none
// ============================================================================
// Module   : text_console
// Purpose  : Teletype-style writer for an 80x25 text frame buffer, with
//            cursor tracking, memory-copy scrolling and screen clear.
// Revision : 1.0
// ============================================================================
module text_console #(
   parameter logic [15:0] BASE = 16'h0000,
   parameter int          COLS = 80,
   parameter int          ROWS = 25,
   parameter logic [7:0]  ATTR = 8'h07
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  char_data,
   input  logic        char_valid,
   output logic        char_ready,
   output logic [15:0] address,
   input  logic [7:0]  in,
   output logic [7:0]  out,
   output logic        we,
   output logic [10:0] cursor,
   output logic        busy
);

   localparam int CELLS  = COLS * ROWS;
   localparam int COPY_N = 2 * COLS * (ROWS - 1);
   localparam int FILL_N = 2 * COLS;
   localparam int CLR_N  = 2 * CELLS;
   localparam int IW     = $clog2(CLR_N);
   localparam int XW     = $clog2(COLS + 1);

   localparam logic [10:0]   LAST_CELL = 11'(CELLS - 1);
   localparam logic [10:0]   LAST_ROW  = 11'(COLS * (ROWS - 1));
   localparam logic [11:0]   CELLS_W   = 12'(CELLS);
   localparam logic [11:0]   COLS_W    = 12'(COLS);
   localparam logic [XW-1:0] LAST_COL  = XW'(COLS - 1);
   localparam logic [IW-1:0] COPY_LAST = IW'(COPY_N - 1);
   localparam logic [IW-1:0] FILL_LAST = IW'(FILL_N - 1);
   localparam logic [IW-1:0] CLR_LAST  = IW'(CLR_N - 1);
   localparam logic [15:0]   SRC_BASE  = BASE + 16'(2 * COLS);
   localparam logic [15:0]   FILL_BASE = BASE + 16'(COPY_N);
   localparam logic [7:0]    BLANK     = 8'h20;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WCHR   = 3'd1,
      S_WATR   = 3'd2,
      S_SCR_RD = 3'd3,
      S_SCR_WR = 3'd4,
      S_FILL   = 3'd5,
      S_CLR    = 3'd6
   } state_t;

   state_t        state_q, state_d;
   logic [10:0]   cursor_q, cursor_d;
   logic [XW-1:0] col_q, col_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [7:0]    char_q, char_d;

   logic [15:0]   cell_addr;
   logic [11:0]   lf_sum;

   // Column is tracked alongside the cursor so no divider is needed.
   assign cell_addr  = BASE + 16'({cursor_q, 1'b0});
   assign lf_sum     = {1'b0, cursor_q} + COLS_W;
   assign char_ready = (state_q == S_IDLE) && !reset;
   assign cursor     = cursor_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cursor_q <= '0;
         col_q    <= '0;
         idx_q    <= '0;
         char_q   <= '0;
      end else begin
         state_q  <= state_d;
         cursor_q <= cursor_d;
         col_q    <= col_d;
         idx_q    <= idx_d;
         char_q   <= char_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cursor_d = cursor_q;
      col_d    = col_q;
      idx_d    = idx_q;
      char_d   = char_q;
      address  = BASE;
      out      = 8'h00;
      we       = 1'b0;
      busy     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (char_valid && char_ready) begin
               unique case (char_data)
                  8'h0D: begin
                     cursor_d = cursor_q - 11'(col_q);
                     col_d    = '0;
                  end
                  8'h0A: begin
                     if (lf_sum >= CELLS_W) begin
                        idx_d   = '0;
                        state_d = S_SCR_RD;
                     end else begin
                        cursor_d = lf_sum[10:0];
                     end
                  end
                  8'h08: begin
                     if (col_q != '0) begin
                        cursor_d = cursor_q - 11'd1;
                        col_d    = col_q - XW'(1);
                     end
                  end
                  8'h0C: begin
                     idx_d   = '0;
                     state_d = S_CLR;
                  end
                  default: begin
                     char_d  = char_data;
                     state_d = S_WCHR;
                  end
               endcase
            end
         end

         S_WCHR: begin
            we      = 1'b1;
            address = cell_addr;
            out     = char_q;
            state_d = S_WATR;
         end

         S_WATR: begin
            we      = 1'b1;
            address = cell_addr + 16'd1;
            out     = ATTR;
            // Wrapping off the last cell jumps straight to the bottom row start.
            if (cursor_q == LAST_CELL) begin
               cursor_d = LAST_ROW;
               col_d    = '0;
               idx_d    = '0;
               state_d  = S_SCR_RD;
            end else begin
               cursor_d = cursor_q + 11'd1;
               col_d    = (col_q == LAST_COL) ? '0 : col_q + XW'(1);
               state_d  = S_IDLE;
            end
         end

         S_SCR_RD: begin
            busy    = 1'b1;
            address = SRC_BASE + 16'(idx_q);
            state_d = S_SCR_WR;
         end

         S_SCR_WR: begin
            busy    = 1'b1;
            we      = 1'b1;
            address = BASE + 16'(idx_q);
            out     = in;
            if (idx_q == COPY_LAST) begin
               idx_d   = '0;
               state_d = S_FILL;
            end else begin
               idx_d   = idx_q + IW'(1);
               state_d = S_SCR_RD;
            end
         end

         S_FILL: begin
            busy    = 1'b1;
            we      = 1'b1;
            address = FILL_BASE + 16'(idx_q);
            out     = idx_q[0] ? ATTR : BLANK;
            if (idx_q == FILL_LAST) begin
               idx_d   = '0;
               state_d = S_IDLE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end

         S_CLR: begin
            busy    = 1'b1;
            we      = 1'b1;
            address = BASE + 16'(idx_q);
            out     = idx_q[0] ? ATTR : BLANK;
            if (idx_q == CLR_LAST) begin
               idx_d    = '0;
               cursor_d = '0;
               col_d    = '0;
               state_d  = S_IDLE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_text_console.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_console
// Purpose  : Directed self-checking bench for text_console with a byte memory.
// Revision : 1.0
// ============================================================================
module tb_text_console;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  char_data;
   logic        char_valid;
   logic        char_ready;
   logic [15:0] address;
   logic [7:0]  mem_rd;
   logic [7:0]  mem_wr;
   logic        we;
   logic [10:0] cursor;
   logic        busy;

   logic [7:0]  mem [0:4095];
   logic        preload;
   int          wr_cnt   = 0;
   int          busy_tot = 0;
   int          checks   = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   text_console #(
      .BASE (16'h0000),
      .COLS (80),
      .ROWS (25),
      .ATTR (8'h07)
   ) dut (
      .clock      (clk),
      .reset      (reset),
      .char_data  (char_data),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .address    (address),
      .in         (mem_rd),
      .out        (mem_wr),
      .we         (we),
      .cursor     (cursor),
      .busy       (busy)
   );

   // Row r of the screen is preloaded with the value r in every byte.
   always @(posedge clk) begin
      mem_rd <= mem[address[11:0]];
      if (preload) begin
         for (int i = 0; i < 4000; i++) mem[i] <= 8'(i / 160);
      end else if (we) begin
         mem[address[11:0]] <= mem_wr;
      end
      if (we) wr_cnt <= wr_cnt + 1;
      if (busy) busy_tot <= busy_tot + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!char_ready && n < 20000) begin
         step();
         n++;
      end
      if (!char_ready) chk("ready_timeout", char_ready, 1);
   endtask

   // Returns in the cycle after the accept edge.
   task automatic accept(input logic [7:0] b);
      wait_ready();
      char_data  = b;
      char_valid = 1'b1;
      step();
      char_valid = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      accept(b);
      wait_ready();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   initial begin
      int b0;
      int w0;
      int errs;
      logic [7:0] e;

      reset      = 1'b1;
      char_valid = 1'b0;
      char_data  = 8'h00;
      preload    = 1'b0;
      step();
      step();
      chk("rst_we", we, 0);
      chk("rst_addr", address, 16'h0000);
      chk("rst_out", mem_wr, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_cursor", cursor, 0);
      chk("rst_ready", char_ready, 0);
      reset = 1'b0;
      step();
      chk("ready_after_rst", char_ready, 1);

      // Single printable at cursor 0
      accept(8'h41);
      chk("A_t1_we", we, 1);
      chk("A_t1_addr", address, 0);
      chk("A_t1_out", mem_wr, 8'h41);
      chk("A_t1_ready", char_ready, 0);
      step();
      chk("A_t2_we", we, 1);
      chk("A_t2_addr", address, 1);
      chk("A_t2_out", mem_wr, 8'h07);
      chk("A_t2_cursor", cursor, 0);
      step();
      chk("A_t3_ready", char_ready, 1);
      chk("A_t3_cursor", cursor, 1);
      chk("A_t3_we", we, 0);
      chk("A_mem0", mem[0], 8'h41);
      chk("A_mem1", mem[1], 8'h07);

      // CR and BS handling
      do_reset();
      for (int i = 0; i < 5; i++) send(8'h48 + 8'(i));
      chk("five_cursor", cursor, 5);
      accept(8'h0D);
      chk("cr_cursor", cursor, 0);
      chk("cr_ready", char_ready, 1);
      accept(8'h08);
      chk("bs_col0_cursor", cursor, 0);
      for (int i = 0; i < 3; i++) send(8'h61 + 8'(i));
      chk("three_cursor", cursor, 3);
      chk("three_mem4", mem[4], 8'h63);
      w0 = wr_cnt;
      accept(8'h08);
      chk("bs_cursor", cursor, 2);
      chk("bs_ready", char_ready, 1);
      step();
      chk("bs_no_write", wr_cnt - w0, 0);

      // LF scroll from the last row
      do_reset();
      for (int i = 0; i < 24; i++) send(8'h0A);
      chk("lf24_cursor", cursor, 1920);
      preload = 1'b1;
      step();
      preload = 1'b0;
      chk("preload_row1", mem[160], 1);
      b0 = busy_tot;
      accept(8'h0A);
      chk("lf_scroll_busy", busy, 1);
      chk("lf_scroll_cursor", cursor, 1920);
      wait_ready();
      chk("lf_busy_cycles", busy_tot - b0, 7840);
      chk("lf_post_cursor", cursor, 1920);
      errs = 0;
      for (int i = 0; i < 3840; i++) if (mem[i] !== 8'(i / 160 + 1)) errs++;
      chk("scroll_copy_errs", errs, 0);
      errs = 0;
      for (int i = 3840; i < 4000; i++) begin
         e = (i % 2 == 1) ? 8'h07 : 8'h20;
         if (mem[i] !== e) errs++;
      end
      chk("scroll_fill_errs", errs, 0);
      chk("scroll_mem3839", mem[3839], 24);

      // Printable wrap at the last cell
      for (int i = 0; i < 79; i++) send(8'h2E);
      chk("cursor_1999", cursor, 1999);
      b0 = busy_tot;
      accept(8'h5A);
      chk("wrap_t1_addr", address, 3998);
      chk("wrap_t1_out", mem_wr, 8'h5A);
      step();
      chk("wrap_t2_addr", address, 3999);
      chk("wrap_t2_out", mem_wr, 8'h07);
      step();
      chk("wrap_t3_cursor", cursor, 1920);
      chk("wrap_t3_busy", busy, 1);
      chk("wrap_t3_ready", char_ready, 0);
      wait_ready();
      chk("wrap_busy_cycles", busy_tot - b0, 7840);
      chk("wrap_cursor", cursor, 1920);
      chk("wrap_mem3838", mem[3838], 8'h5A);
      chk("wrap_mem3839", mem[3839], 8'h07);
      chk("wrap_mem3680", mem[3680], 8'h2E);
      chk("wrap_mem3998", mem[3998], 8'h20);

      // Form feed, with a byte offered while busy that must be ignored
      b0 = busy_tot;
      w0 = wr_cnt;
      accept(8'h0C);
      chk("ff_t1_busy", busy, 1);
      chk("ff_t1_addr", address, 0);
      chk("ff_t1_out", mem_wr, 8'h20);
      char_data  = 8'h51;
      char_valid = 1'b1;
      for (int i = 0; i < 50; i++) step();
      char_valid = 1'b0;
      wait_ready();
      chk("ff_busy_cycles", busy_tot - b0, 4000);
      chk("ff_writes", wr_cnt - w0, 4000);
      chk("ff_cursor", cursor, 0);
      errs = 0;
      for (int i = 0; i < 4000; i++) begin
         e = (i % 2 == 1) ? 8'h07 : 8'h20;
         if (mem[i] !== e) errs++;
      end
      chk("ff_mem_errs", errs, 0);

      // Reset in the middle of a scroll
      for (int i = 0; i < 24; i++) send(8'h0A);
      accept(8'h0A);
      for (int i = 0; i < 100; i++) step();
      chk("mid_busy", busy, 1);
      reset = 1'b1;
      step();
      chk("abort_we", we, 0);
      chk("abort_cursor", cursor, 0);
      chk("abort_busy", busy, 0);
      chk("abort_ready_in_rst", char_ready, 0);
      reset = 1'b0;
      #1;
      chk("abort_ready", char_ready, 1);
      step();
      chk("abort_addr", address, 0);
      chk("abort_idle_we", we, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/text_console.md
# text_console

Teletype-style writer for the 80x25 text-mode frame buffer. It accepts a byte stream of characters and control codes and writes character/attribute pairs into the shared byte-wide video memory. It maintains the hardware cursor and scrolls the screen by copying memory. It sits on the CPU side of the video memory port, so the character display has a producer that needs no software.

## Interface
Parameters:
- BASE, 16'h0000, byte address of cell 0 (character byte; attribute at +1)
- COLS, 80, characters per row
- ROWS, 25, rows per screen
- ATTR, 8'h07, attribute byte written with every character and blank

Ports:
- clock  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- char_data  in  8  character or control code
- char_valid  in  1  char_data is offered this cycle
- char_ready  out  1  block accepts a byte this cycle
- address  out  16  video memory byte address
- in  in  8  memory read data, valid one cycle after address
- out  out  8  memory write data
- we  out  1  memory write enable for this cycle
- cursor  out  11  linear cursor position, 0..COLS*ROWS-1
- busy  out  1  scroll or clear in progress

## Operation
- A byte is accepted on a cycle where char_valid && char_ready. char_ready = (state == IDLE) && !reset.
- The cell address is BASE + 2*cursor, computed modulo 2^16.
- Byte decoding, where col = cursor mod COLS:
  - 8'h0D (CR): cursor -= col. No memory write.
  - 8'h0A (LF): cursor += COLS. If the result is >= COLS*ROWS, the cursor stays in the last row at the same col and a SCROLL runs.
  - 8'h08 (BS): if col > 0 then cursor -= 1, else no change. Nothing is erased.
  - 8'h0C (FF): CLEAR, then cursor = 0.
  - Any other byte: write char_data at the cell address, then ATTR at +1, then cursor += 1. If cursor reaches COLS*ROWS, cursor = COLS*(ROWS-1) and a SCROLL runs.
- States: IDLE, WCHR, WATR, SCR_RD, SCR_WR, FILL, CLR.
- IDLE transitions:
  - printable → WCHR → WATR → IDLE, or → SCR_RD when wrapping
  - LF in the last row → SCR_RD
  - FF → CLR
  - CR/BS update the cursor in the accept cycle and stay in IDLE
- SCROLL:
  - Index i runs 0..2*COLS*(ROWS-1)-1.
  - SCR_RD drives address = BASE+2*COLS+i with we=0.
  - SCR_WR drives address = BASE+i, out = in, we=1, then increments i.
  - After the last i, go to FILL.
  - FILL writes 2*COLS bytes from BASE+2*COLS*(ROWS-1), alternating 8'h20 and ATTR, one per cycle, then returns to IDLE.
- CLR writes 2*COLS*ROWS bytes from BASE, alternating 8'h20/ATTR, one per cycle, then sets cursor = 0 and returns to IDLE.
- busy = 1 in SCR_RD, SCR_WR, FILL and CLR.

## Timing
- Reset values: state IDLE, cursor 0, we 0, address BASE, out 8'h00, busy 0, scroll/clear index 0. char_ready is 0 while reset is high and 1 on the first cycle after.
- Printable byte accepted in cycle T:
  - T+1: we=1, address=cell, out=char
  - T+2: we=1, address=cell+1, out=ATTR; cursor updates at the end of T+2
  - T+3: char_ready=1, or the first SCR_RD cycle
- CR/BS: cursor is updated on the clock edge ending the accept cycle; char_ready stays 1.
- Scroll: 2 cycles per copied byte plus 1 per fill byte, which is 2*3840 + 160 = 7840 cycles at defaults.
- Clear: 4000 cycles at defaults.
- The copy never overlaps a destination before its source is read, because the source address is always greater than the destination address.
- cursor is registered. It holds its post-wrap value (1920 at defaults) for the whole scroll and never presents 2000.
- we is asserted only in WCHR, WATR, SCR_WR, FILL and CLR.
- Reset mid-operation: the operation aborts immediately and reset values apply on the next cycle. Memory contents are left partially updated, with no completion.
- char_valid held while char_ready=0 is ignored; the byte is not consumed.

## Test plan
- Reset, then send 'A' (8'h41) at cursor 0. Required: writes 8'h41 to BASE and 8'h07 to BASE+1 on consecutive cycles, cursor=1, char_ready back three cycles after accept.
- Send 5 printables, then CR, then BS. Required: cursor 5 → 0 → 0. Send 3 printables then BS. Required: cursor=2, no memory write for the BS.
- Preload memory row r, byte j with value r. Set cursor=1920 via LF×24 and send LF. Required: busy for exactly 7840 cycles, bytes 0..3839 equal the old bytes 160..3999, bytes 3840..3999 alternate 8'h20/8'h07, cursor=1920.
- Write a printable at cursor 1999. Required: char and attribute written at BASE+3998/3999 before the scroll, then cursor=1920 after the scroll, and the copied character ends up at BASE+3838.
- Send FF. Required: 4000 writes alternating 8'h20/8'h07 from BASE, cursor=0, busy high for 4000 cycles.
- Assert reset mid-scroll. Required: the next cycle shows we=0, cursor=0, busy=0, and char_ready=1 after reset deasserts.
